// File: rtl/hack_pkg.sv
// hack_pkg: word width, default address widths and FSM
// encoding shared by the Hack run controller and its timer.
package hack_pkg;

    localparam int WORD_W          = 16;
    localparam int ROM_AW_DEF      = 15;
    localparam int RAM_AW_DEF      = 15;
    localparam int RESULT_ADDR_DEF = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_PRESET0 = 3'd2;
    localparam state_t S_PRESET1 = 3'd3;
    localparam state_t S_RUN     = 3'd4;
    localparam state_t S_READ    = 3'd5;
    localparam state_t S_CAPTURE = 3'd6;
    localparam state_t S_DONE    = 3'd7;

endpackage

// File: rtl/hack_run_timer.sv
// hack_run_timer: loadable down-counter that measures the
// CPU run window; zero flags the final run cycle.
module hack_run_timer
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              en,
    input  logic [WORD_W-1:0] din,
    output logic              zero
);

    logic [WORD_W-1:0] r_count;

    // Load wins over counting; counting stops at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= din;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/hack_run_controller.sv
// hack_run_controller: owns the Hack CPU reset and memory
// back-doors; loads ROM, presets args, runs, reads result.
module hack_run_controller
    import hack_pkg::*;
#(
    parameter int ROM_AW      = ROM_AW_DEF,
    parameter int RAM_AW      = RAM_AW_DEF,
    parameter int RESULT_ADDR = RESULT_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              reload,
    input  logic [WORD_W-1:0] arg0,
    input  logic [WORD_W-1:0] arg1,
    input  logic [WORD_W-1:0] run_cycles,
    input  logic              abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              cpu_reset,
    output logic              mem_own,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              load_err
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_arg0;
    logic [WORD_W-1:0] r_arg1;
    logic [WORD_W-1:0] r_budget;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [WORD_W-1:0] r_ram_wdata;
    logic [WORD_W-1:0] r_result;
    logic              r_load_err;
    logic              w_accept;
    logic              w_beat;
    logic              w_rom_full;
    logic              w_run_zero;
    logic [WORD_W-1:0] w_timer_din;

    assign w_accept    = (r_state == S_IDLE) && start && !abort;
    assign w_beat      = (r_state == S_LOAD) && load_valid;
    assign w_rom_full  = &r_rom_addr;
    // RUN exits on the cycle the counter shows zero, so load N-1.
    assign w_timer_din = r_budget - 1'b1;

    hack_run_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (r_state == S_PRESET1),
        .en      (r_state == S_RUN),
        .din     (w_timer_din),
        .zero    (w_run_zero)
    );

    // Next-state decode; abort overrides everything outside IDLE.
    always_comb begin
        w_next = r_state;
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) w_next = reload ? S_LOAD : S_PRESET0;
                end
                S_LOAD: begin
                    if (w_beat && load_last)      w_next = S_PRESET0;
                    else if (w_beat && w_rom_full) w_next = S_DONE;
                end
                S_PRESET0: w_next = S_PRESET1;
                S_PRESET1: w_next = (r_budget == '0) ? S_READ : S_RUN;
                S_RUN:     if (w_run_zero) w_next = S_READ;
                S_READ:    w_next = S_CAPTURE;
                S_CAPTURE: w_next = S_DONE;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // State, command latches, load counter, result and RAM port regs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_arg0      <= '0;
            r_arg1      <= '0;
            r_budget    <= '0;
            r_rom_addr  <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_result    <= '0;
            r_load_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_arg0     <= arg0;
                r_arg1     <= arg1;
                r_budget   <= run_cycles;
                r_load_err <= 1'b0;
                r_rom_addr <= '0;
            end else if (w_beat) begin
                r_rom_addr <= r_rom_addr + 1'b1;
                if (!load_last && w_rom_full && !abort) begin
                    r_load_err <= 1'b1;
                end
            end
            if ((r_state == S_CAPTURE) && !abort) begin
                r_result <= ram_rdata;
            end
            case (w_next)
                S_PRESET0: begin
                    r_ram_addr  <= '0;
                    r_ram_wdata <= (r_state == S_IDLE) ? arg0 : r_arg0;
                end
                S_PRESET1: begin
                    r_ram_addr  <= RAM_AW'(1);
                    r_ram_wdata <= r_arg1;
                end
                S_READ: begin
                    r_ram_addr <= RAM_AW'(RESULT_ADDR);
                end
                default: begin
                end
            endcase
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign cpu_reset  = (r_state != S_RUN) || abort;
    assign mem_own    = (r_state != S_RUN);
    assign rom_we     = w_beat;
    assign rom_addr   = r_rom_addr;
    assign rom_wdata  = load_data;
    assign ram_we     = (r_state == S_PRESET0) || (r_state == S_PRESET1);
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign result     = r_result;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_hack_run_controller.sv
// tb_hack_run_controller: directed + randomized commands against
// a mock Computer (RAM/ROM arrays, CPU computing max into RAM[2]).
module tb_hack_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_a, start_b, reload, abort;
    logic        load_valid, load_last;
    logic [15:0] arg0, arg1, run_cycles, load_data;

    logic        a_load_ready, a_cpu_reset, a_mem_own, a_rom_we;
    logic        a_ram_we, a_busy, a_done, a_load_err;
    logic [14:0] a_rom_addr, a_ram_addr;
    logic [15:0] a_rom_wdata, a_ram_wdata, a_result;
    logic [15:0] a_ram_rdata = 16'h0;

    logic        b_load_ready, b_cpu_reset, b_mem_own, b_rom_we;
    logic        b_ram_we, b_busy, b_done, b_load_err;
    logic [3:0]  b_rom_addr;
    logic [14:0] b_ram_addr;
    logic [15:0] b_rom_wdata, b_ram_wdata, b_result;

    hack_run_controller u_dut (
        .clk(clk), .reset_n(reset_n), .start(start_a), .reload(reload),
        .arg0(arg0), .arg1(arg1), .run_cycles(run_cycles), .abort(abort),
        .load_valid(load_valid), .load_ready(a_load_ready),
        .load_data(load_data), .load_last(load_last),
        .cpu_reset(a_cpu_reset), .mem_own(a_mem_own),
        .rom_we(a_rom_we), .rom_addr(a_rom_addr), .rom_wdata(a_rom_wdata),
        .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy), .done(a_done),
        .result(a_result), .load_err(a_load_err)
    );

    hack_run_controller #(.ROM_AW(4)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start_b), .reload(reload),
        .arg0(arg0), .arg1(arg1), .run_cycles(run_cycles), .abort(abort),
        .load_valid(load_valid), .load_ready(b_load_ready),
        .load_data(load_data), .load_last(load_last),
        .cpu_reset(b_cpu_reset), .mem_own(b_mem_own),
        .rom_we(b_rom_we), .rom_addr(b_rom_addr), .rom_wdata(b_rom_wdata),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(16'h0), .busy(b_busy), .done(b_done),
        .result(b_result), .load_err(b_load_err)
    );

    // Mock Computer: registered-read RAM, ROM, CPU that keeps
    // RAM[2] = max(RAM[0], RAM[1]) on every clock it runs.
    logic [15:0] ram_m [8] = '{default: 16'h0};
    logic [15:0] rom_m [64];
    int rom_we_cnt = 0;
    int run_clk_cnt = 0;
    int done_cnt = 0;
    int b_run_cnt = 0;

    always @(posedge clk) begin
        if (a_rom_we) begin
            rom_m[a_rom_addr[5:0]] <= a_rom_wdata;
            rom_we_cnt <= rom_we_cnt + 1;
        end
        if (a_ram_we && a_mem_own) ram_m[a_ram_addr[2:0]] <= a_ram_wdata;
        if (!a_cpu_reset) begin
            ram_m[2] <= (ram_m[0] > ram_m[1]) ? ram_m[0] : ram_m[1];
            run_clk_cnt <= run_clk_cnt + 1;
        end
        a_ram_rdata <= ram_m[a_ram_addr[2:0]];
        if (a_done) done_cnt <= done_cnt + 1;
        if (!b_cpu_reset) b_run_cnt <= b_run_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] prog [16];
    logic [15:0] m_ram2 = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] umax(input logic [15:0] a, b);
        return (a > b) ? a : b;
    endfunction

    // One host command on the main DUT, checked against the model.
    task automatic run_cmd(input logic rl, input int nw, input bit gap,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] n, input bit poke,
                           input string tag);
        int cyc, run0, we0, done0;
        logic [15:0] exp_res, prior;
        run0  = run_clk_cnt;
        we0   = rom_we_cnt;
        done0 = done_cnt;
        prior = a_result;
        arg0 = a0; arg1 = a1; run_cycles = n; reload = rl;
        chk({tag, " idle"}, a_busy, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 1;
        chk({tag, " busy"}, a_busy, 1);
        if (rl) begin
            for (int i = 0; i < nw; i++) begin
                if (gap) begin
                    load_valid = 1'b0;
                    tick();
                    cyc++;
                end
                load_valid = 1'b1;
                load_data  = prog[i];
                load_last  = (i == nw - 1);
                tick();
                cyc++;
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
        end
        if (poke) begin
            arg0 = ~a0; arg1 = ~a1; run_cycles = 16'd3; start_a = 1'b1;
            tick();
            tick();
            cyc += 2;
            start_a = 1'b0;
        end
        while (a_done !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk({tag, " done"}, a_done, 1);
        // Start cycle counts as the first of 1+2+n+2+1.
        if (!rl) chk({tag, " latency"}, cyc, 1 + 2 + n + 2 + 1 - 1);
        exp_res = (n != 0) ? umax(a0, a1) : m_ram2;
        m_ram2  = exp_res;
        chk({tag, " result"}, a_result, exp_res);
        chk({tag, " ram0"}, ram_m[0], a0);
        chk({tag, " ram1"}, ram_m[1], a1);
        chk({tag, " run clocks"}, run_clk_cnt - run0, n);
        chk({tag, " rom writes"}, rom_we_cnt - we0, rl ? nw : 0);
        chk({tag, " busy at done"}, a_busy, 1);
        if (rl) begin
            for (int i = 0; i < nw; i++) chk({tag, " rom"}, rom_m[i], prog[i]);
        end
        tick();
        chk({tag, " done pulse"}, a_done, 0);
        chk({tag, " back idle"}, a_busy, 0);
        chk({tag, " done count"}, done_cnt - done0, 1);
        if (prior === 16'hx) chk({tag, " prior"}, 1, 0);
    endtask

    initial begin
        int cyc, done0, run0;
        logic [15:0] prior, ra, rb;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; reload = 1'b0;
        abort = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        arg0 = '0; arg1 = '0; run_cycles = '0; load_data = '0;
        #2;
        chk("rst cpu_reset", a_cpu_reset, 1);
        chk("rst mem_own", a_mem_own, 1);
        chk("rst busy", a_busy, 0);
        chk("rst done", a_done, 0);
        chk("rst result", a_result, 0);
        chk("rst load_err", a_load_err, 0);
        chk("rst load_ready", a_load_ready, 0);
        chk("rst rom_we", a_rom_we, 0);
        chk("rst ram_we", a_ram_we, 0);
        chk("rst rom_addr", a_rom_addr, 0);
        chk("rst ram_addr", a_ram_addr, 0);
        chk("rst wdata", {a_ram_wdata, a_rom_wdata}, 0);
        chk("rst b outs", {b_cpu_reset, b_mem_own, b_busy, b_done,
            b_load_err, b_load_ready, b_rom_we, b_ram_we}, 8'b1100_0000);
        chk("rst b addr", {b_rom_addr, b_ram_addr, b_result}, 0);
        chk("rst b wdata", {b_rom_wdata, b_ram_wdata}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        run_cmd(1'b1, 16, 1'b0, 16'd2, 16'd3, 16'd50, 1'b0, "prog");
        run_cmd(1'b0, 0, 1'b0, 16'd566, 16'd3,
                16'($urandom_range(1, 30)), 1'b0, "566");
        run_cmd(1'b0, 0, 1'b0, 16'd5, 16'd5,
                16'($urandom_range(1, 30)), 1'b1, "five");
        for (int k = 0; k < 6; k++) begin
            run_cmd(1'b0, 0, 1'b0, 16'($urandom), 16'($urandom),
                    (k == 2) ? 16'd0 : 16'($urandom_range(1, 40)),
                    k[0], "rand");
        end

        prior = a_result;
        done0 = done_cnt;
        run0  = run_clk_cnt;
        ra = 16'($urandom);
        rb = 16'($urandom);
        arg0 = ra; arg1 = rb; run_cycles = 16'd40; reload = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (a_cpu_reset !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("abort run entered", a_cpu_reset, 0);
        repeat (9) tick();
        abort = 1'b1;
        #1;
        chk("abort cpu_reset now", a_cpu_reset, 1);
        tick();
        chk("abort idle", a_busy, 0);
        chk("abort cpu_reset", a_cpu_reset, 1);
        chk("abort no done", a_done, 0);
        chk("abort result", a_result, prior);
        abort = 1'b0;
        tick();
        tick();
        chk("abort done count", done_cnt - done0, 0);
        chk("abort run clocks", run_clk_cnt - run0, 9);
        m_ram2 = umax(ra, rb);

        for (int i = 0; i < 6; i++) prog[i] = 16'($urandom);
        run_cmd(1'b1, 6, 1'b1, 16'($urandom), 16'($urandom), 16'd0,
                1'b0, "gap");

        run0 = b_run_cnt;
        reload = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = 16'($urandom);
            load_last  = 1'b0;
            tick();
            if (i == 14) chk("err early done", b_done, 0);
        end
        load_valid = 1'b0;
        chk("err done", b_done, 1);
        chk("err flag", b_load_err, 1);
        tick();
        chk("err done pulse", b_done, 0);
        chk("err idle", b_busy, 0);
        chk("err flag held", b_load_err, 1);
        chk("err no run", b_run_cnt - run0, 0);
        chk("err result", b_result, 0);
        reload = 1'b0; run_cycles = 16'd0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("err cleared", b_load_err, 0);
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("err rerun done", b_done, 1);
        tick();

        reload = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid rst busy", a_busy, 0);
        chk("mid rst cpu_reset", a_cpu_reset, 1);
        chk("mid rst mem_own", a_mem_own, 1);
        chk("mid rst load_ready", a_load_ready, 0);
        chk("mid rst rom_we", a_rom_we, 0);
        chk("mid rst rom_addr", a_rom_addr, 0);
        chk("mid rst result", a_result, 0);
        chk("mid rst done", {a_done, a_load_err, a_ram_we}, 0);
        load_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
